// File: rtl/led_cmd_scheduler_pkg.sv
// Shared types for the LED command scheduler: operation and state encodings,
// the IR remote code table and the IR byte decoder.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_TOGGLE_BUZ
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_HOLD
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] digit;
  } cmd_t;

  localparam logic [7:0] IR_DIGIT_0    = 8'h68;
  localparam logic [7:0] IR_DIGIT_1    = 8'h30;
  localparam logic [7:0] IR_DIGIT_2    = 8'h18;
  localparam logic [7:0] IR_DIGIT_3    = 8'h7A;
  localparam logic [7:0] IR_DIGIT_4    = 8'h10;
  localparam logic [7:0] IR_DIGIT_5    = 8'h38;
  localparam logic [7:0] IR_DIGIT_6    = 8'h5A;
  localparam logic [7:0] IR_DIGIT_7    = 8'h42;
  localparam logic [7:0] IR_DIGIT_8    = 8'h4A;
  localparam logic [7:0] IR_DIGIT_9    = 8'h52;
  localparam logic [7:0] IR_INC        = 8'hA8;
  localparam logic [7:0] IR_DEC        = 8'hE0;
  localparam logic [7:0] IR_TOGGLE_BUZ = 8'h90;

  localparam logic [3:0] LED_MAX = 4'hF;

  // Map an IR command byte to an operation; unknown bytes come back as OP_NOP.
  function automatic cmd_t ir_decode(input logic [7:0] code);
    cmd_t cmd;
    cmd.op    = OP_NOP;
    cmd.digit = 4'd0;
    case (code)
      IR_DIGIT_0:    begin cmd.op = OP_LOAD; cmd.digit = 4'd0; end
      IR_DIGIT_1:    begin cmd.op = OP_LOAD; cmd.digit = 4'd1; end
      IR_DIGIT_2:    begin cmd.op = OP_LOAD; cmd.digit = 4'd2; end
      IR_DIGIT_3:    begin cmd.op = OP_LOAD; cmd.digit = 4'd3; end
      IR_DIGIT_4:    begin cmd.op = OP_LOAD; cmd.digit = 4'd4; end
      IR_DIGIT_5:    begin cmd.op = OP_LOAD; cmd.digit = 4'd5; end
      IR_DIGIT_6:    begin cmd.op = OP_LOAD; cmd.digit = 4'd6; end
      IR_DIGIT_7:    begin cmd.op = OP_LOAD; cmd.digit = 4'd7; end
      IR_DIGIT_8:    begin cmd.op = OP_LOAD; cmd.digit = 4'd8; end
      IR_DIGIT_9:    begin cmd.op = OP_LOAD; cmd.digit = 4'd9; end
      IR_INC:        cmd.op = OP_INC;
      IR_DEC:        cmd.op = OP_DEC;
      IR_TOGGLE_BUZ: cmd.op = OP_TOGGLE_BUZ;
      default:       cmd.op = OP_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/led_cmd_scheduler_if.sv
// IR request strobe plus the LED/buzzer/status outputs of the scheduler.
interface led_cmd_if;
  logic       irq_i;
  logic [7:0] command_i;
  logic [3:0] led_o;
  logic       buzzer_en_o;
  logic       beep_o;
  logic       busy_o;
  logic       op_done_o;
  logic       drop_o;

  modport master (
    output irq_i, command_i,
    input  led_o, buzzer_en_o, beep_o, busy_o, op_done_o, drop_o
  );

  modport slave (
    input  irq_i, command_i,
    output led_o, buzzer_en_o, beep_o, busy_o, op_done_o, drop_o
  );
endinterface

// File: rtl/led_cmd_scheduler_btn_sync_edge.sv
// Synchroniser and press-edge detector for one active-low push-button.
// press is high for one cycle each time the synchronised level goes
// from released (1) to pressed (0).
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the raw pin through the synchroniser and remember the previous level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/led_cmd_scheduler.sv
// LED/buzzer command scheduler: collects IR and button requests into two
// pending slots, grants them round-robin, applies one op at a time with a
// hold-off afterwards and gates an acknowledgment beep.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | nothing in flight; grants a pending slot if any
// ST_APPLY | granted op is written into led/buzzer on the next edge
// ST_HOLD  | hold-off timer running; on its last cycle a pending slot is
//          | granted directly so back-to-back work keeps busy_o high
module led_cmd_scheduler
  import led_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int BEEP_CYCLES = 2_500_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     btn_inc_n_i,
  input  logic     btn_dec_n_i,
  input  logic     btn_buz_n_i,
  led_cmd_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);

  logic press_inc, press_dec, press_buz;

  cmd_t   btn_req, ir_req, ir_slot, btn_slot, cur;
  logic   btn_req_vld, btn_lost, ir_req_vld, ir_bad;
  logic   ir_vld, btn_vld, rr_btn;
  logic   grant_ir, grant_btn, contested;
  state_e state, state_nxt;

  logic [HOLD_W-1:0] hold_cnt;
  logic [BEEP_W-1:0] beep_cnt;
  logic [3:0]        led_q, led_nxt;
  logic              buz_q, buz_nxt;
  logic              beep_start, beep_stop;
  logic              op_done_q, drop_q;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
    .clk(clk_i), .rst(rst_i), .btn_n(btn_inc_n_i), .press(press_inc)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dec (
    .clk(clk_i), .rst(rst_i), .btn_n(btn_dec_n_i), .press(press_dec)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_buz (
    .clk(clk_i), .rst(rst_i), .btn_n(btn_buz_n_i), .press(press_buz)
  );

  // Resolve same-cycle button edges with fixed priority inc > dec > buz.
  always_comb begin
    btn_req.op    = OP_NOP;
    btn_req.digit = 4'd0;
    btn_req_vld   = press_inc | press_dec | press_buz;
    btn_lost      = (press_inc & (press_dec | press_buz)) | (press_dec & press_buz);
    if (press_inc)      btn_req.op = OP_INC;
    else if (press_dec) btn_req.op = OP_DEC;
    else if (press_buz) btn_req.op = OP_TOGGLE_BUZ;
  end

  // Decode the IR byte; unknown codes become a drop instead of a request.
  always_comb begin
    ir_req     = ir_decode(bus.command_i);
    ir_req_vld = bus.irq_i && (ir_req.op != OP_NOP);
    ir_bad     = bus.irq_i && (ir_req.op == OP_NOP);
  end

  // Next state and grant decision.
  always_comb begin
    logic arbitrate;
    state_nxt = state;
    grant_ir  = 1'b0;
    grant_btn = 1'b0;
    contested = 1'b0;
    arbitrate = 1'b0;
    case (state)
      ST_IDLE:  arbitrate = 1'b1;
      ST_APPLY: state_nxt = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = ST_IDLE;
          arbitrate = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (arbitrate) begin
      if (ir_vld && btn_vld) begin
        contested = 1'b1;
        grant_ir  = ~rr_btn;
        grant_btn = rr_btn;
      end else begin
        grant_ir  = ir_vld;
        grant_btn = btn_vld;
      end
      if (grant_ir || grant_btn) state_nxt = ST_APPLY;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Pending slots, round-robin pointer, granted op and drop pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_vld   <= 1'b0;
      btn_vld  <= 1'b0;
      ir_slot  <= '{op: OP_NOP, digit: 4'd0};
      btn_slot <= '{op: OP_NOP, digit: 4'd0};
      cur      <= '{op: OP_NOP, digit: 4'd0};
      rr_btn   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (contested) rr_btn <= ~rr_btn;

      if (grant_ir)       cur <= ir_slot;
      else if (grant_btn) cur <= btn_slot;

      // A request landing on the clearing edge refills the slot.
      if (ir_req_vld) begin
        ir_slot <= ir_req;
        ir_vld  <= 1'b1;
      end else if (grant_ir) begin
        ir_vld  <= 1'b0;
      end

      if (btn_req_vld && (!btn_vld || grant_btn)) begin
        btn_slot <= btn_req;
        btn_vld  <= 1'b1;
      end else if (grant_btn) begin
        btn_vld  <= 1'b0;
      end

      drop_q <= ir_bad | (ir_req_vld & ir_vld & ~grant_ir)
              | btn_lost | (btn_req_vld & btn_vld & ~grant_btn);
    end
  end

  // Hold-off down-counter, loaded as the op is applied.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 hold_cnt <= '0;
    else if (state == ST_APPLY)                hold_cnt <= HOLD_LOAD;
    else if (state == ST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  // Result of the granted op, with saturation and beep decision.
  always_comb begin
    led_nxt = led_q;
    buz_nxt = buz_q;
    case (cur.op)
      OP_LOAD:       led_nxt = cur.digit;
      OP_INC:        if (led_q != LED_MAX) led_nxt = led_q + 4'd1;
      OP_DEC:        if (led_q != 4'd0)    led_nxt = led_q - 4'd1;
      OP_TOGGLE_BUZ: buz_nxt = ~buz_q;
      default:       ;
    endcase
    beep_start = (cur.op == OP_TOGGLE_BUZ) ? buz_nxt : ((led_nxt != led_q) && buz_q);
    beep_stop  = (cur.op == OP_TOGGLE_BUZ) && !buz_nxt;
  end

  // Register the op result and the op_done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q     <= 4'd0;
      buz_q     <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      op_done_q <= (state == ST_APPLY);
      if (state == ST_APPLY) begin
        led_q <= led_nxt;
        buz_q <= buz_nxt;
      end
    end
  end

  // Beep down-counter: restarted by a trigger, cleared when the buzzer turns off.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 beep_cnt <= '0;
    else if (state == ST_APPLY && beep_start)  beep_cnt <= BEEP_LOAD;
    else if (state == ST_APPLY && beep_stop)   beep_cnt <= '0;
    else if (beep_cnt != '0)                   beep_cnt <= beep_cnt - BEEP_W'(1);
  end

  assign bus.led_o       = led_q;
  assign bus.buzzer_en_o = buz_q;
  assign bus.beep_o      = (beep_cnt != '0);
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.op_done_o   = op_done_q;
  assign bus.drop_o      = drop_q;

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Self-checking bench for led_cmd_scheduler with HOLD=4, BEEP=3, SYNC=2.
// Expected LED/buzzer/beep behaviour comes from an op-level model that
// applies each command's arithmetic to a shadow LED value and buzzer flag.
module tb_led_cmd_scheduler;

  localparam int HOLD = 4;
  localparam int BEEP = 3;
  localparam int K_NONE = 0, K_LOAD = 1, K_INC = 2, K_DEC = 3, K_TOG = 4;
  localparam logic [7:0] DIGIT_CODE [10] =
    '{8'h68, 8'h30, 8'h18, 8'h7A, 8'h10, 8'h38, 8'h5A, 8'h42, 8'h4A, 8'h52};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc_n = 1'b1, btn_dec_n = 1'b1, btn_buz_n = 1'b1;

  int checks = 0;
  int errors = 0;
  int m_led = 0;
  int m_buz = 0;

  led_cmd_if bus ();

  led_cmd_scheduler #(.HOLD_CYCLES(HOLD), .BEEP_CYCLES(BEEP), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .btn_inc_n_i(btn_inc_n), .btn_dec_n_i(btn_dec_n), .btn_buz_n_i(btn_buz_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void tb_decode(input logic [7:0] code, output int kind, output int digit);
    kind = K_NONE;
    digit = 0;
    for (int i = 0; i < 10; i++)
      if (code == DIGIT_CODE[i]) begin kind = K_LOAD; digit = i; end
    if (code == 8'hA8) kind = K_INC;
    if (code == 8'hE0) kind = K_DEC;
    if (code == 8'h90) kind = K_TOG;
  endfunction

  // Apply one op to the shadow state; returns whether it should beep.
  function automatic int model_op(input int kind, input int digit);
    int old = m_led;
    case (kind)
      K_LOAD: m_led = digit;
      K_INC:  m_led = (m_led == 15) ? 15 : m_led + 1;
      K_DEC:  m_led = (m_led == 0) ? 0 : m_led - 1;
      K_TOG:  m_buz = 1 - m_buz;
      default: ;
    endcase
    if (kind == K_TOG) return m_buz;
    return (m_led != old && m_buz == 1) ? 1 : 0;
  endfunction

  task automatic set_btn(input int idx, input logic lvl);
    case (idx)
      0: btn_inc_n = lvl;
      1: btn_dec_n = lvl;
      default: btn_buz_n = lvl;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_led = 0;
    m_buz = 0;
    check("rst led", bus.led_o, 0);
    check("rst buz", bus.buzzer_en_o, 0);
    check("rst beep", bus.beep_o, 0);
    check("rst busy", bus.busy_o, 0);
    check("rst op_done", bus.op_done_o, 0);
    check("rst drop", bus.drop_o, 0);
  endtask

  // Called on the cycle the applied result is visible; runs until idle.
  task automatic expect_apply(input int kind, input int digit, input string tag);
    int trig, beeps, dones, n;
    trig = model_op(kind, digit);
    check({tag, " led"}, bus.led_o, m_led);
    check({tag, " buz"}, bus.buzzer_en_o, m_buz);
    check({tag, " op_done"}, bus.op_done_o, 1);
    beeps = int'(bus.beep_o);
    dones = 0;
    n = 0;
    while (bus.busy_o && n < 50) begin
      tick();
      n++;
      beeps += int'(bus.beep_o);
      dones += int'(bus.op_done_o);
    end
    check({tag, " idle"}, bus.busy_o, 0);
    check({tag, " beep_len"}, beeps, trig ? BEEP : 0);
    check({tag, " extra_done"}, dones, 0);
  endtask

  task automatic ir_op(input logic [7:0] code, input string tag);
    int kind, digit, busy_seen;
    tb_decode(code, kind, digit);
    bus.irq_i = 1'b1;
    bus.command_i = code;
    tick();
    bus.irq_i = 1'b0;
    if (kind == K_NONE) begin
      check({tag, " drop"}, bus.drop_o, 1);
      busy_seen = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        busy_seen += int'(bus.busy_o);
      end
      check({tag, " busy"}, busy_seen, 0);
      check({tag, " led"}, bus.led_o, m_led);
    end else begin
      check({tag, " drop"}, bus.drop_o, 0);
      tick();
      check({tag, " early_led"}, bus.led_o, m_led);
      tick();
      expect_apply(kind, digit, tag);
    end
  endtask

  task automatic btn_op(input int idx, input string tag);
    int kind;
    kind = (idx == 0) ? K_INC : (idx == 1) ? K_DEC : K_TOG;
    set_btn(idx, 1'b0);
    tick(); tick(); tick();
    check({tag, " drop"}, bus.drop_o, 0);
    tick(); tick();
    expect_apply(kind, 0, tag);
    set_btn(idx, 1'b1);
    tick(); tick(); tick();
  endtask

  initial begin
    int ones, drops, dones, busy_low, n, r;
    logic [7:0] code;
    bus.irq_i = 1'b0;
    bus.command_i = 8'h00;
    tick();

    // Reset and a first LOAD 8 with the buzzer off.
    do_reset();
    ir_op(8'h4A, "load8");

    // Buzzer on, then climb to 15 and saturate.
    ir_op(8'h90, "buz_on");
    ir_op(8'h52, "load9");
    for (int i = 0; i < 6; i++) ir_op(8'hA8, "inc_up");
    ir_op(8'hA8, "inc_sat");

    // IR DEC and an inc press land together: IR first, then the button.
    ir_op(8'h38, "load5");
    btn_inc_n = 1'b0;
    tick(); tick();
    bus.irq_i = 1'b1;
    bus.command_i = 8'hE0;
    tick();
    bus.irq_i = 1'b0;
    check("arb drop", bus.drop_o, 0);
    tick();
    check("arb busy_grant", bus.busy_o, 1);
    tick();
    void'(model_op(K_DEC, 0));
    check("arb ir_led", bus.led_o, m_led);
    check("arb ir_done", bus.op_done_o, 1);
    busy_low = 0;
    for (int i = 0; i < HOLD + 1; i++) begin
      tick();
      busy_low += int'(!bus.busy_o);
    end
    check("arb busy_low", busy_low, 0);
    void'(model_op(K_INC, 0));
    check("arb btn_led", bus.led_o, m_led);
    check("arb btn_done", bus.op_done_o, 1);
    btn_inc_n = 1'b1;
    n = 0;
    while (bus.busy_o && n < 50) begin tick(); n++; end
    check("arb idle", bus.busy_o, 0);
    tick(); tick(); tick();

    // Two IR strobes during HOLD: the second overwrites the first.
    bus.irq_i = 1'b1;
    bus.command_i = 8'h68;
    tick();
    bus.irq_i = 1'b0;
    tick(); tick();
    void'(model_op(K_LOAD, 0));
    check("ovr load0", bus.led_o, m_led);
    bus.irq_i = 1'b1;
    bus.command_i = 8'h30;
    tick();
    check("ovr drop_first", bus.drop_o, 0);
    bus.command_i = 8'h18;
    tick();
    bus.irq_i = 1'b0;
    check("ovr drop_second", bus.drop_o, 1);
    drops = 0;
    n = 0;
    while (!bus.op_done_o && n < 20) begin
      tick();
      n++;
      drops += int'(bus.drop_o);
    end
    check("ovr extra_drop", drops, 0);
    void'(model_op(K_LOAD, 2));
    check("ovr led", bus.led_o, m_led);
    check("ovr done", bus.op_done_o, 1);
    n = 0;
    while (bus.busy_o && n < 50) begin tick(); n++; end
    check("ovr idle", bus.busy_o, 0);

    // Inc and dec pressed together and held.
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    tick(); tick(); tick();
    check("pair drop", bus.drop_o, 1);
    tick(); tick();
    void'(model_op(K_INC, 0));
    check("pair led", bus.led_o, m_led);
    check("pair done", bus.op_done_o, 1);
    dones = 0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dones += int'(bus.op_done_o);
      drops += int'(bus.drop_o);
    end
    check("pair held_done", dones, 0);
    check("pair held_drop", drops, 0);
    check("pair held_led", bus.led_o, m_led);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    tick(); tick(); tick();

    // Reset during HOLD with both slots full.
    bus.irq_i = 1'b1;
    bus.command_i = 8'h10;
    tick();
    bus.irq_i = 1'b0;
    tick(); tick();
    void'(model_op(K_LOAD, 4));
    check("rsth load4", bus.led_o, m_led);
    bus.irq_i = 1'b1;
    bus.command_i = 8'h42;
    btn_buz_n = 1'b0;
    tick();
    bus.irq_i = 1'b0;
    tick(); tick();
    check("rsth busy", bus.busy_o, 1);
    btn_buz_n = 1'b1;
    do_reset();
    dones = 0;
    ones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      dones += int'(bus.op_done_o);
      ones += int'(bus.busy_o);
    end
    check("rsth no_done", dones, 0);
    check("rsth no_busy", ones, 0);
    check("rsth led", bus.led_o, 0);

    // Unknown code.
    ir_op(8'hFF, "unknown");

    // Randomized sequence of IR codes and single button presses.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        n = $urandom_range(0, 15);
        if (n < 10)       code = DIGIT_CODE[n];
        else if (n == 10) code = 8'hA8;
        else if (n == 11) code = 8'hE0;
        else if (n == 12) code = 8'h90;
        else              code = 8'($urandom_range(0, 255));
        ir_op(code, "rnd_ir");
      end else begin
        btn_op($urandom_range(0, 2), "rnd_btn");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_cmd_scheduler.md
Name: led_cmd_scheduler

Overview:
- Owns the 4-bit LED value and the buzzer enable for the board.
- Serialises requests from two sources: the IR remote (irq_i/command_i from the NEC decoder) and three raw push-buttons.
- Arbitrates round-robin, applies one operation at a time, enforces a hold-off between operations, and produces a timed beep acknowledgment.
- Sits between the IR decoder/button pins and the LED/buzzer pads.

Parameters:
- HOLD_CYCLES, 5_000_000: idle cycles enforced after each applied op (100 ms at 50 MHz); 0 means no hold.
- BEEP_CYCLES, 2_500_000: beep_o pulse length in cycles; must be at least 1.
- SYNC_STAGES, 2: flip-flop stages in each button synchroniser; must be at least 2.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- btn_inc_n_i  in  1  raw increment button, active-low, asynchronous.
- btn_dec_n_i  in  1  raw decrement button, active-low, asynchronous.
- btn_buz_n_i  in  1  raw buzzer-toggle button, active-low, asynchronous.
- irq_i  in  1  one-cycle strobe; command_i is valid while it is high.
- command_i  in  8  IR command byte.
- led_o  out  4  current LED value.
- buzzer_en_o  out  1  buzzer enable.
- beep_o  out  1  acknowledgment tone gate.
- busy_o  out  1  high when the FSM is not in IDLE.
- op_done_o  out  1  one-cycle pulse when an op is applied.
- drop_o  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset (one clock edge with rst_i=1):
  - led_o=0, buzzer_en_o=0, beep_o=0, busy_o=0, op_done_o=0, drop_o=0.
  - FSM=IDLE; both pending slots empty; round-robin pointer favours IR.
  - Synchronisers and counters cleared.
  - Reset mid-operation aborts everything; pending requests are lost.
- Buttons:
  - Each button passes through a SYNC_STAGES synchroniser, then a press-edge detector (released to pressed).
  - One cycle of edge output per press.
  - Same-cycle edges are resolved inc > dec > buz; the losing edges are dropped with drop_o=1.
- IR decode:
  - 0x68,0x30,0x18,0x7A,0x10,0x38,0x5A,0x42,0x4A,0x52 → LOAD 0..9 respectively.
  - 0xA8 → INC; 0xE0 → DEC; 0x90 → TOGGLE_BUZ.
  - Any other code is discarded: drop_o pulses and no pending entry is made.
- Pending slots: one for IR, one for buttons, each holding an op and a value.
  - A new IR request while the IR slot is full overwrites it (last wins); drop_o pulses.
  - A new button edge while the button slot is full is discarded; drop_o pulses.
- FSM: IDLE → APPLY → HOLD → IDLE.
  - IDLE: if any slot is full, grant it and go to APPLY.
    - If both are full, grant the source not granted last (initially IR) and flip the pointer.
    - The granted slot is cleared on that edge.
    - A request arriving on the same edge as a clear refills the slot.
  - APPLY (one cycle):
    - Register the op result into led_o/buzzer_en_o.
    - Pulse op_done_o, coincident with the new led_o value.
    - Next state is HOLD, or IDLE when HOLD_CYCLES=0.
  - HOLD: count HOLD_CYCLES cycles, then go to IDLE. Requests are still captured into the slots during HOLD.
- Latency: irq_i sampled at edge k → slot full after k → APPLY entered at edge k+1 → led_o updates at edge k+2.
- Arithmetic:
  - INC at 15 leaves led_o at 15. DEC at 0 leaves led_o at 0.
  - A saturated op still counts as applied: op_done_o pulses, but no beep.
  - LOAD writes the zero-extended digit.
- Beep:
  - Triggered by an applied op that changes led_o (LOAD, INC or DEC) while buzzer_en_o=1 after that edge.
  - Also triggered by TOGGLE_BUZ that enables the buzzer.
  - beep_o is high for exactly BEEP_CYCLES cycles starting the cycle after APPLY.
  - A new trigger restarts the count.
  - TOGGLE_BUZ that disables the buzzer clears beep_o immediately.
- busy_o = (state != IDLE).

Decomposition:
- Package led_ctrl_pkg holds:
  - enum op_e {OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_TOGGLE_BUZ};
  - IR code localparams;
  - function ir_decode(byte) returning op plus digit;
  - FSM state enum.
- One sub-module, btn_sync_edge: synchroniser plus press-edge detector for an active-low button. It is instantiated three times.

Test Plan (HOLD_CYCLES=4, BEEP_CYCLES=3, SYNC_STAGES=2):
- Reset, then IR 0x4A strobe → led_o=8 exactly 2 cycles after the strobe edge; op_done_o pulses once; beep_o stays 0 because the buzzer is off.
- IR 0x90 → buzzer_en_o=1 and beep_o high for 3 cycles; then IR 0xA8 with led_o=15 → led_o stays 15, op_done_o=1, beep_o stays 0.
- IR 0xE0 and an inc press arriving in the same cycle, with led_o=5 → IR is served first (led_o=4); the button is served after 4 hold cycles (led_o=5); busy_o stays high throughout.
- Two IR strobes (0x30 then 0x18) during HOLD → drop_o pulses once; the next LOAD gives led_o=2.
- Inc and dec pressed together → only inc is applied; drop_o=1 for the dec edge; holding the button down produces no further edges.
- Assert rst_i during HOLD with both slots full → all outputs return to their reset values next edge; no op is applied afterwards.
- Unknown code 0xFF → drop_o=1; led_o unchanged; busy_o stays 0.
